// File: rtl/lab9_div.sv
// lab9_div: sequential restoring divider, one quotient bit per clock.
// It is the inverse of the lab9 shift-add multiplier: it takes the product
// width as dividend and the operand width as divisor, and returns quotient
// and remainder. A zero divisor finishes in a single cycle with the
// quotient saturated to all ones and div_by_zero raised.

module lab9_div #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] in_dividend,
    input  logic [VW-1:0] in_divisor,
    output logic [DW-1:0] out_q,
    output logic [VW-1:0] out_r,
    output logic          out_valid,
    output logic          div_by_zero,
    output logic          busy
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    // Working registers. The partial remainder is kept to VW bits because
    // the restoring step always leaves it strictly below the divisor; the
    // extra bit of the shifted trial value only lives in w_trial.
    logic [VW-1:0] r_pr;
    logic [DW-1:0] r_q;
    logic [VW-1:0] r_d;
    logic [CW-1:0] r_cnt;

    // Visible result registers, updated only on completion or reset.
    logic [DW-1:0] r_outQ;
    logic [VW-1:0] r_outR;
    logic          r_valid;
    logic          r_dbz;

    logic [VW-1:0] w_prNext;
    logic [DW-1:0] w_qNext;
    logic [VW-1:0] w_dNext;
    logic [CW-1:0] w_cntNext;
    logic [DW-1:0] w_outQNext;
    logic [VW-1:0] w_outRNext;
    logic          w_validNext;
    logic          w_dbzNext;

    // One restoring iteration: shift the next dividend bit into the partial
    // remainder and try to subtract the divisor.
    logic [VW:0]   w_trial;
    logic [VW:0]   w_diff;
    logic          w_ge;
    logic [VW-1:0] w_prIter;
    logic [DW-1:0] w_qIter;
    logic          w_lastIter;

    // Combinational datapath for a single iteration. Since the partial
    // remainder is below the divisor, the trial value is below twice the
    // divisor, so the VW+1 bit difference is negative exactly when the trial
    // is smaller than the divisor; its top bit is therefore the borrow of
    // the unsigned VW+1 bit compare.
    always_comb begin
        w_trial    = {r_pr, r_q[DW-1]};
        w_diff     = w_trial - {1'b0, r_d};
        w_ge       = ~w_diff[VW];
        w_prIter   = w_ge ? w_diff[VW-1:0] : w_trial[VW-1:0];
        w_qIter    = {r_q[DW-2:0], w_ge};
        w_lastIter = (r_cnt == CW'(DW - 1));
    end

    // State register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and next-register logic. Start is honoured in IDLE and
    // DONE only; while a division runs it is ignored so the operands and
    // latency of the running division are untouched.
    always_comb begin
        w_stateNext = r_state;
        w_prNext    = r_pr;
        w_qNext     = r_q;
        w_dNext     = r_d;
        w_cntNext   = r_cnt;
        w_outQNext  = r_outQ;
        w_outRNext  = r_outR;
        w_validNext = r_valid;
        w_dbzNext   = r_dbz;

        unique case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_dNext   = in_divisor;
                    w_qNext   = in_dividend;
                    w_prNext  = '0;
                    w_cntNext = '0;
                    if (in_divisor == '0) begin
                        w_stateNext = DONE;
                        w_outQNext  = '1;
                        w_outRNext  = '0;
                        w_validNext = 1'b1;
                        w_dbzNext   = 1'b1;
                    end else begin
                        w_stateNext = BUSY;
                        w_validNext = 1'b0;
                        w_dbzNext   = 1'b0;
                    end
                end
            end

            BUSY: begin
                w_prNext  = w_prIter;
                w_qNext   = w_qIter;
                w_cntNext = r_cnt + 1'b1;
                if (w_lastIter) begin
                    w_stateNext = DONE;
                    w_outQNext  = w_qIter;
                    w_outRNext  = w_prIter;
                    w_validNext = 1'b1;
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Datapath and result registers; reset abandons any running division.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_pr    <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_outQ  <= '0;
            r_outR  <= '0;
            r_valid <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_pr    <= w_prNext;
            r_q     <= w_qNext;
            r_d     <= w_dNext;
            r_cnt   <= w_cntNext;
            r_outQ  <= w_outQNext;
            r_outR  <= w_outRNext;
            r_valid <= w_validNext;
            r_dbz   <= w_dbzNext;
        end
    end

    assign out_q       = r_outQ;
    assign out_r       = r_outR;
    assign out_valid   = r_valid;
    assign div_by_zero = r_dbz;
    assign busy        = (r_state == BUSY);

endmodule

// File: tb/tb_lab9_div.sv
// tb_lab9_div: self-checking bench for lab9_div. A behavioural model built
// from plain integer division tracks what every output must show on every
// cycle; directed operations also pin the model against hand-computed values.

module tb_lab9_div;

    localparam int DW = 16;
    localparam int VW = 8;

    logic          CLK = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] in_dividend;
    logic [VW-1:0] in_divisor;
    logic [DW-1:0] out_q;
    logic [VW-1:0] out_r;
    logic          out_valid;
    logic          div_by_zero;
    logic          busy;

    int checks = 0;
    int errors = 0;
    logic compareOn = 1'b0;

    lab9_div #(.DW(DW), .VW(VW)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .start       (start),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .out_q       (out_q),
        .out_r       (out_r),
        .out_valid   (out_valid),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: a division is either pending (counting down the
    // cycles until its result appears) or not, results from / and %.
    logic          mBusy;
    logic          mValid;
    logic          mDbz;
    int            mLeft;
    logic [DW-1:0] mQ;
    logic [VW-1:0] mR;
    logic [DW-1:0] mPendQ;
    logic [VW-1:0] mPendR;

    always @(posedge CLK or posedge reset) begin
        if (reset) begin
            mBusy  <= 1'b0;
            mValid <= 1'b0;
            mDbz   <= 1'b0;
            mLeft  <= 0;
            mQ     <= '0;
            mR     <= '0;
            mPendQ <= '0;
            mPendR <= '0;
        end else if (mBusy) begin
            if (mLeft == 1) begin
                mBusy  <= 1'b0;
                mValid <= 1'b1;
                mQ     <= mPendQ;
                mR     <= mPendR;
            end else begin
                mLeft <= mLeft - 1;
            end
        end else if (start) begin
            if (in_divisor == 0) begin
                mValid <= 1'b1;
                mDbz   <= 1'b1;
                mQ     <= '1;
                mR     <= '0;
            end else begin
                mBusy  <= 1'b1;
                mLeft  <= DW;
                mValid <= 1'b0;
                mDbz   <= 1'b0;
                mPendQ <= in_dividend / in_divisor;
                mPendR <= VW'(in_dividend % in_divisor);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        if (compareOn) begin
            checkOutput("cyc_busy", busy, mBusy);
            checkOutput("cyc_valid", out_valid, mValid);
            checkOutput("cyc_dbz", div_by_zero, mDbz);
            checkOutput("cyc_q", out_q, mQ);
            checkOutput("cyc_r", out_r, mR);
        end
    end

    // Presents one operand pair for exactly one rising edge; returns on the
    // falling edge right after the accepting edge.
    task automatic applyStimulus(input logic [DW-1:0] a, input logic [VW-1:0] b);
        @(negedge CLK);
        start       = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Full directed operation with literal expectations and latency checks.
    task automatic runOp(input int a, input int b, input int eq, input int er);
        applyStimulus(a[DW-1:0], b[VW-1:0]);
        #2;
        checkOutput("start_valid", out_valid, (b == 0) ? 1 : 0);
        checkOutput("start_busy", busy, (b == 0) ? 0 : 1);
        if (b != 0) begin
            repeat (DW - 1) @(negedge CLK);
            #2;
            checkOutput("pre_valid", out_valid, 0);
            @(negedge CLK);
            #2;
        end
        checkOutput("done_valid", out_valid, 1);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_dbz", div_by_zero, (b == 0) ? 1 : 0);
        checkOutput("done_q", out_q, eq);
        checkOutput("done_r", out_r, er);
        checkOutput("model_q", mQ, eq);
        checkOutput("model_r", mR, er);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        repeat (2) @(negedge CLK);
        #2;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_q", out_q, 0);
        checkOutput("rst_r", out_r, 0);
        checkOutput("rst_dbz", div_by_zero, 0);
        reset = 1'b0;
        compareOn = 1'b1;

        runOp(27, 9, 3, 0);
        repeat (20) @(negedge CLK);
        #2;
        checkOutput("hold_valid", out_valid, 1);
        checkOutput("hold_q", out_q, 3);
        checkOutput("hold_r", out_r, 0);

        runOp(11211, 101, 111, 0);
        runOp(861, 7, 123, 0);
        runOp(60000, 7, 8571, 3);
        runOp(65535, 255, 257, 0);

        runOp(5, 200, 0, 5);
        runOp(65535, 1, 65535, 0);
        runOp(0, 13, 0, 0);

        runOp(1234, 0, 65535, 0);
        runOp(140, 14, 10, 0);

        // A second start while busy must be ignored.
        applyStimulus(16'd50000, 8'd3);
        repeat (4) @(negedge CLK);
        start       = 1'b1;
        in_dividend = 16'd10;
        in_divisor  = 8'd2;
        @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        #2;
        checkOutput("ign_pre_valid", out_valid, 0);
        @(negedge CLK);
        #2;
        checkOutput("ign_valid", out_valid, 1);
        checkOutput("ign_q", out_q, 16666);
        checkOutput("ign_r", out_r, 2);

        // Reset in the middle of a division abandons it.
        applyStimulus(16'd60000, 8'd7);
        repeat (7) @(negedge CLK);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_q", out_q, 0);
        checkOutput("midrst_r", out_r, 0);
        checkOutput("midrst_dbz", div_by_zero, 0);
        @(negedge CLK);
        reset = 1'b0;
        repeat (20) @(negedge CLK);
        #2;
        checkOutput("midrst_novalid", out_valid, 0);
        runOp(60, 1, 60, 0);

        // Random traffic: starts in every state, zero and small divisors,
        // and the occasional asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            start       = ($urandom_range(0, 7) == 0);
            in_dividend = DW'($urandom);
            case ($urandom_range(0, 9))
                0:       in_divisor = '0;
                1, 2:    in_divisor = VW'($urandom_range(1, 3));
                default: in_divisor = VW'($urandom);
            endcase
            if ($urandom_range(0, 599) == 0) begin
                #3;
                reset = 1'b1;
                #2;
                reset = 1'b0;
            end
        end
        @(negedge CLK);
        start = 1'b0;
        repeat (DW + 2) @(negedge CLK);

        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab9_div.md
Name: lab9_div

Overview:
- Sequential restoring divider that computes one quotient bit per clock. It is the inverse of the lab9 shift-add multiplier.
- Takes the multiplier's 16-bit product width as the dividend and its 8-bit operand width as the divisor. Produces quotient and remainder with an out_valid flag.
- Used in the Lab9 exercises to recover a multiplier operand from a product. A bench can chain multiplier -> divider and check that the original operand comes back.

Parameters:
- DW, 16, dividend and quotient width in bits.
- VW, 8, divisor and remainder width in bits; VW <= DW.

Ports:
- CLK  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  operand-load request, sampled on rising CLK.
- in_dividend  input  DW  dividend, sampled with start.
- in_divisor  input  VW  divisor, sampled with start.
- out_q  output  DW  quotient.
- out_r  output  VW  remainder.
- out_valid  output  1  out_q/out_r hold a finished result.
- div_by_zero  output  1  last accepted divisor was 0.
- busy  output  1  division in progress.

Behaviour:
- Reset (async, reset=1): state=IDLE. out_q=0, out_r=0, out_valid=0, div_by_zero=0, busy=0. Internal PR, Q, divisor register and iteration counter cleared.
- Reset mid-operation: the computation is abandoned and no out_valid is produced. After reset release the block waits for a new start.
- States: IDLE, BUSY, DONE.
- IDLE, start=1 at edge k:
  - Latch divisor D=in_divisor, Q=in_dividend, PR=0 (VW+1 bits), cnt=0.
  - If D!=0 -> BUSY, busy=1.
  - If D==0 -> DONE, div_by_zero=1, out_q={DW{1'b1}}, out_r=0, out_valid=1, all visible after edge k.
- BUSY, each edge performs one iteration:
  - T={PR[VW-1:0],Q[DW-1]}; Q={Q[DW-2:0],1'b0}.
  - If T>=D: PR=T-D, Q[0]=1. Else PR=T.
  - cnt=cnt+1.
  - The compare is unsigned and VW+1 bits wide, so carry into bit VW is kept.
- BUSY, completion: on the edge where cnt reaches DW-1 (the DW-th iteration, edge k+DW):
  - Transition to DONE, busy=0, out_valid=1.
  - out_q = final Q; out_r = final PR[VW-1:0].
- Latency: start at edge k -> out_valid=1 after edge k+DW (16 cycles by default). Divide-by-zero takes 1 cycle.
- DONE: out_valid, out_q, out_r and div_by_zero hold indefinitely.
- start=1 in DONE:
  - Accepted exactly as in IDLE.
  - out_valid and div_by_zero drop to 0 at that edge, unless the new divisor is 0.
  - out_q/out_r keep their old values until the new result is written.
- start=1 in BUSY: ignored. Operands are not re-sampled and latency is unchanged.
- out_q and out_r change only on completion or reset; they never show intermediate values.
- Arithmetic rules:
  - Results are unsigned: in_dividend = out_q*in_divisor + out_r, with out_r < in_divisor.
  - The quotient may use all DW bits, e.g. divisor 1 gives out_q = dividend.
- Dividend < divisor: out_q=0, out_r=dividend[VW-1:0], normal DW-cycle latency.

Test Plan:
- Reset pulse; start with 27/9 -> out_valid=0 for 15 cycles, then out_valid=1 after 16th edge with out_q=3, out_r=0, busy=0; values hold for 20 further cycles.
- Back-to-back runs: start in DONE for each of 11211/101 -> q=111 r=0; 861/7 -> q=123 r=0; 60000/7 -> q=8571 r=3; 65535/255 -> q=257 r=0. Each run: out_valid drops at the start edge and rises 16 cycles later.
- Boundaries: 5/200 -> q=0, r=5; 65535/1 -> q=65535, r=0; 0/13 -> q=0, r=0.
- Divisor 0 with dividend 1234 -> after 1 cycle out_valid=1, div_by_zero=1, out_q=65535, out_r=0. A following 140/14 -> div_by_zero=0, q=10, r=0.
- Start 50000/3; assert start again at cycle 5 with 10/2 -> second start ignored; result q=16666 r=2 at cycle 16.
- Start 60000/7; pulse reset at cycle 8 -> all outputs 0 immediately and no out_valid. A new start with 60/1 -> q=60, r=0 after 16 cycles.
